cwc_probe_frontend: RTL and testbench
=====================================

CWC_PROBE_FRONTEND -- requirements
Module: cwc_probe_frontend

Interface
REQ-001 SHALL have parameter LINE_SKIP, default 0: number of whole lines after frame start skipped before capture (0..2047).
REQ-002 SHALL have parameter CAP_PIXELS, default 1024: number of DE-qualified pixels flagged per capture (1..4095).
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port vs_i, input, 1: video vertical sync, active-high.
REQ-006 SHALL have port de_i, input, 1: data enable, active-high.
REQ-007 SHALL have port cha_data_i, input, 8: channel A pixel byte.
REQ-008 SHALL have port chb_data_i, input, 8: channel B pixel byte.
REQ-009 SHALL have port arm_i, input, 1: level arm request from the debug host.
REQ-010 SHALL have port sel_i, input, 2: probe data mux select.
REQ-011 SHALL have port probe0, output, 1: DE aligned with the probe data.
REQ-012 SHALL have port probe1, output, 8: first probe byte.
REQ-013 SHALL have port probe2, output, 8: second probe byte.
REQ-014 SHALL have port probe3, output, 1: capture-window flag, used as the ChipWatcher trigger.
REQ-015 SHALL have port state_o, output, 3: current FSM state.
REQ-016 SHALL have port mismatch_cnt_o, output, 16: A/B mismatch count for the current or last capture.

Function
REQ-017 SHALL register all inputs through two stages (s1, s2); vs and de SHALL get a third stage s3 for edge detection.
REQ-018 SHALL detect frame start as s2_vs=1 and s3_vs=0, and line start as s2_de=1 and s3_de=0.
REQ-019 SHALL register probe0..probe3 from s2 data, giving exactly 3 clk of latency from inputs to probes; all four probes SHALL be mutually cycle-aligned.
REQ-020 SHALL drive probe0 = de for the same pixel as probe1/probe2.
REQ-021 SHALL select probe1/probe2 by sel_i (sampled at s2):
- 0: A, B.
- 1: A, A XOR B.
- 2: line_cnt[7:0], pix_cnt[7:0].
- 3: B, A.
REQ-022 SHALL clear pix_cnt (12 bit) to 0 on line start and increment it on each subsequent s2_de cycle; it SHALL saturate at 4095.
REQ-023 SHALL clear line_cnt (11 bit) to 0 on frame start and increment it on each later line start; it SHALL saturate at 2047.
REQ-024 SHALL implement FSM states IDLE=0, WAIT_FRAME=1, SKIP=2, CAPTURE=3, DONE=4, with state_o equal to the state encoding.
REQ-025 SHALL transition IDLE->WAIT_FRAME when arm_i=1.
REQ-026 SHALL transition WAIT_FRAME->SKIP on frame start.
REQ-027 SHALL transition SKIP->CAPTURE so that the first captured pixel is pixel 0 of line index LINE_SKIP (line 0 = first DE run after frame start); with LINE_SKIP=0 this is the first line.
REQ-028 SHALL transition CAPTURE->DONE after CAP_PIXELS DE-qualified pixels have been flagged.
REQ-029 SHALL transition DONE->IDLE when arm_i=0.
REQ-030 SHALL force any state to IDLE on the cycle after arm_i (s2) is observed low, deasserting probe3 at the next probe update.
REQ-031 SHALL drive probe3=1 exactly for the CAP_PIXELS DE-high pixels of the capture window, including across line boundaries and DE gaps, and 0 otherwise.
REQ-032 SHALL ignore a frame start during SKIP, CAPTURE or DONE; capture spans frames if needed.
REQ-033 SHALL clear mismatch_cnt_o to 0 on entry to CAPTURE.
REQ-034 SHALL increment mismatch_cnt_o by 1 for each flagged pixel with A != B; it SHALL saturate at 16'hFFFF and hold its value in DONE and IDLE until the next capture.
REQ-035 SHALL not change the probe data path with arm_i or FSM state; probe0..probe2 stream continuously.

Reset
REQ-036 SHALL, while rst_n=0, set all pipeline registers, counters, probe0..probe3 and mismatch_cnt_o to 0 and state_o to IDLE, with no clock required.
REQ-037 SHALL take its first FSM transition on the first clk edge after rst_n deassertion, and probe outputs SHALL be valid 3 clk after deassertion.

Verification
REQ-038 SHALL cover: sel=0, A=0x5A, B=0xA5, DE=1 -> probe1=0x5A, probe2=0xA5, probe0=1 exactly 3 clk later.
REQ-039 SHALL cover: LINE_SKIP=2, CAP_PIXELS=16, lines of 10 pixels, arm=1, then VS pulse -> probe3 high on line 2 pixels 0..9 and line 3 pixels 0..5, then state_o=4.
REQ-040 SHALL cover: 16 captured pixels with A!=B on 5 of them -> mismatch_cnt_o=5 in DONE, held after arm drops and state_o=0.
REQ-041 SHALL cover: arm_i dropped at captured pixel 7 -> probe3 low from the following probe cycle, state_o=0; re-arm and a new VS -> mismatch count restarts at 0.
REQ-042 SHALL cover: rst_n pulsed low mid-CAPTURE -> all outputs 0 and state_o=0 immediately; after release, no capture until arm plus a new VS.
REQ-043 SHALL cover: sel=2 with 300-pixel lines -> probe2 wraps 0xFF->0x00 at pixel 256 and probe1 increments per line.

Source files
------------

// File: rtl/cwc_probe_frontend.sv
// cwc_probe_frontend: video probe front end for an on-chip logic analyser.
//
// Registers the video inputs through a two-stage synchroniser/pipeline and streams
// a selectable pair of bytes to the probe outputs with a fixed 3 clk latency.
// A small arm/capture FSM raises probe3 for exactly CAP_PIXELS DE-qualified pixels,
// starting at pixel 0 of line LINE_SKIP of the first frame after arming. It also counts
// channel A/B byte mismatches over the capture window.
//
// Ports:
//   clk            - single clock
//   rst_n          - asynchronous active-low reset
//   vs_i, de_i     - vertical sync / data enable (active-high)
//   cha_data_i     - channel A pixel byte
//   chb_data_i     - channel B pixel byte
//   arm_i          - level arm request from the debug host
//   sel_i          - probe data select (0: A,B  1: A,A^B  2: line,pixel  3: B,A)
//   probe0         - DE aligned with probe1/probe2
//   probe1, probe2 - probe bytes
//   probe3         - capture-window flag (analyser trigger)
//   state_o        - FSM state encoding
//   mismatch_cnt_o - A/B mismatch count of the current or last capture
module cwc_probe_frontend #(
  parameter int unsigned LINE_SKIP  = 0,
  parameter int unsigned CAP_PIXELS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [7:0]  cha_data_i,
  input  logic [7:0]  chb_data_i,
  input  logic        arm_i,
  input  logic [1:0]  sel_i,
  output logic        probe0,
  output logic [7:0]  probe1,
  output logic [7:0]  probe2,
  output logic        probe3,
  output logic [2:0]  state_o,
  output logic [15:0] mismatch_cnt_o
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitFrame = 3'd1,
    StSkip      = 3'd2,
    StCapture   = 3'd3,
    StDone      = 3'd4
  } state_e;

  localparam logic [10:0] LineSkipW = 11'(LINE_SKIP);
  localparam logic [11:0] CapPixW   = 12'(CAP_PIXELS);

  // Input pipeline
  logic       r_s1_vs, r_s1_de, r_s1_arm;
  logic [7:0] r_s1_a, r_s1_b;
  logic [1:0] r_s1_sel;
  logic       r_s2_vs, r_s2_de, r_s2_arm;
  logic [7:0] r_s2_a, r_s2_b;
  logic [1:0] r_s2_sel;
  logic       r_s3_vs, r_s3_de;

  // Counters and control
  logic [11:0] r_pix_cnt;
  logic [10:0] r_line_cnt;
  logic        r_line_first;  // next line start is line 0 of the frame
  logic [11:0] r_cap_cnt;
  logic [15:0] r_mm_cnt;
  state_e      r_state;

  // Probe registers
  logic       r_probe0, r_probe3;
  logic [7:0] r_probe1, r_probe2;

  logic        w_frame_start, w_line_start;
  logic [11:0] w_pix_cur;
  logic [10:0] w_line_cur;
  logic        w_line_first_d;
  logic        w_start_cap, w_flag, w_neq;
  logic [11:0] w_cap_next;
  state_e      w_state_d;
  logic [7:0]  w_p1, w_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vs  <= 1'b0;
      r_s1_de  <= 1'b0;
      r_s1_arm <= 1'b0;
      r_s1_a   <= 8'd0;
      r_s1_b   <= 8'd0;
      r_s1_sel <= 2'd0;
      r_s2_vs  <= 1'b0;
      r_s2_de  <= 1'b0;
      r_s2_arm <= 1'b0;
      r_s2_a   <= 8'd0;
      r_s2_b   <= 8'd0;
      r_s2_sel <= 2'd0;
      r_s3_vs  <= 1'b0;
      r_s3_de  <= 1'b0;
    end else begin
      r_s1_vs  <= vs_i;
      r_s1_de  <= de_i;
      r_s1_arm <= arm_i;
      r_s1_a   <= cha_data_i;
      r_s1_b   <= chb_data_i;
      r_s1_sel <= sel_i;
      r_s2_vs  <= r_s1_vs;
      r_s2_de  <= r_s1_de;
      r_s2_arm <= r_s1_arm;
      r_s2_a   <= r_s1_a;
      r_s2_b   <= r_s1_b;
      r_s2_sel <= r_s1_sel;
      r_s3_vs  <= r_s2_vs;
      r_s3_de  <= r_s2_de;
    end
  end

  assign w_frame_start = r_s2_vs & ~r_s3_vs;
  assign w_line_start  = r_s2_de & ~r_s3_de;
  assign w_neq         = (r_s2_a != r_s2_b);

  // Counter values that belong to the pixel currently at s2, so the probes and the
  // capture decision see the index of this very pixel rather than the previous one.
  always_comb begin
    w_pix_cur = r_pix_cnt;
    if (w_line_start) begin
      w_pix_cur = 12'd0;
    end else if (r_s2_de && (r_pix_cnt != 12'hFFF)) begin
      w_pix_cur = r_pix_cnt + 12'd1;
    end

    w_line_cur = r_line_cnt;
    if (w_frame_start || (w_line_start && r_line_first)) begin
      w_line_cur = 11'd0;
    end else if (w_line_start && (r_line_cnt != 11'h7FF)) begin
      w_line_cur = r_line_cnt + 11'd1;
    end

    w_line_first_d = r_line_first;
    if (w_frame_start) begin
      w_line_first_d = ~w_line_start;
    end else if (w_line_start) begin
      w_line_first_d = 1'b0;
    end
  end

  // FSM next state and capture flag
  always_comb begin
    // A frame start coinciding with line start of line LINE_SKIP is captured straight
    // from WAIT_FRAME so pixel 0 is never lost.
    w_start_cap = w_line_start && (w_line_cur == LineSkipW) &&
                  ((r_state == StSkip) || ((r_state == StWaitFrame) && w_frame_start));
    w_flag      = w_start_cap || ((r_state == StCapture) && r_s2_de);
    w_cap_next  = w_start_cap ? 12'd1 : (r_cap_cnt + 12'd1);

    w_state_d = r_state;
    case (r_state)
      StIdle:      if (r_s2_arm) w_state_d = StWaitFrame;
      StWaitFrame: if (w_frame_start) w_state_d = StSkip;
      default:     ;
    endcase
    if (w_start_cap) w_state_d = StCapture;
    if (w_flag && (w_cap_next == CapPixW)) w_state_d = StDone;
    if (!r_s2_arm) w_state_d = StIdle;
  end

  always_comb begin
    w_p1 = r_s2_a;
    w_p2 = r_s2_b;
    case (r_s2_sel)
      2'd1: begin
        w_p1 = r_s2_a;
        w_p2 = r_s2_a ^ r_s2_b;
      end
      2'd2: begin
        w_p1 = w_line_cur[7:0];
        w_p2 = w_pix_cur[7:0];
      end
      2'd3: begin
        w_p1 = r_s2_b;
        w_p2 = r_s2_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt    <= 12'd0;
      r_line_cnt   <= 11'd0;
      r_line_first <= 1'b0;
      r_cap_cnt    <= 12'd0;
      r_mm_cnt     <= 16'd0;
      r_state      <= StIdle;
      r_probe0     <= 1'b0;
      r_probe1     <= 8'd0;
      r_probe2     <= 8'd0;
      r_probe3     <= 1'b0;
    end else begin
      r_pix_cnt    <= w_pix_cur;
      r_line_cnt   <= w_line_cur;
      r_line_first <= w_line_first_d;
      r_state      <= w_state_d;
      if (w_flag) r_cap_cnt <= w_cap_next;
      if (w_start_cap) begin
        r_mm_cnt <= {15'd0, w_neq};
      end else if (w_flag && w_neq && (r_mm_cnt != 16'hFFFF)) begin
        r_mm_cnt <= r_mm_cnt + 16'd1;
      end
      r_probe0 <= r_s2_de;
      r_probe1 <= w_p1;
      r_probe2 <= w_p2;
      r_probe3 <= w_flag;
    end
  end

  assign probe0         = r_probe0;
  assign probe1         = r_probe1;
  assign probe2         = r_probe2;
  assign probe3         = r_probe3;
  assign state_o        = r_state;
  assign mismatch_cnt_o = r_mm_cnt;

endmodule

// File: tb/tb_cwc_probe_frontend.sv
// Self-checking bench for cwc_probe_frontend (LINE_SKIP=2, CAP_PIXELS=16).
// A cycle-level reference model derives the expected probe/state/count values from
// the stimulus, and every posedge its prediction from 3 inputs earlier is compared.
module tb_cwc_probe_frontend;

  localparam int unsigned LS = 2;
  localparam int unsigned CP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs_i = 1'b0;
  logic        de_i = 1'b0;
  logic [7:0]  cha_data_i = 8'd0;
  logic [7:0]  chb_data_i = 8'd0;
  logic        arm_i = 1'b0;
  logic [1:0]  sel_i = 2'd0;
  logic        probe0, probe3;
  logic [7:0]  probe1, probe2;
  logic [2:0]  state_o;
  logic [15:0] mismatch_cnt_o;

  cwc_probe_frontend #(
    .LINE_SKIP (LS),
    .CAP_PIXELS(CP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vs_i          (vs_i),
    .de_i          (de_i),
    .cha_data_i    (cha_data_i),
    .chb_data_i    (chb_data_i),
    .arm_i         (arm_i),
    .sel_i         (sel_i),
    .probe0        (probe0),
    .probe1        (probe1),
    .probe2        (probe2),
    .probe3        (probe3),
    .state_o       (state_o),
    .mismatch_cnt_o(mismatch_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        p0;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic        p3;
    logic [2:0]  st;
    logic [15:0] mm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic arm_lvl = 1'b0;

  // Reference model state (input-time view of the video stream)
  int m_state, m_line, m_pix, m_cap, m_mm;
  bit m_prev_vs, m_prev_de, m_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_line = 0; m_pix = 0; m_cap = 0; m_mm = 0;
    m_prev_vs = 0; m_prev_de = 0; m_first = 0;
    exp_q.delete();
    // Two outputs after release still come from reset-cleared pipeline stages
    repeat (2) exp_q.push_back('0);
  endtask

  task automatic model_step(input bit vs, input bit de, input logic [7:0] a,
                            input logic [7:0] b, input bit arm, input logic [1:0] sel);
    bit   fs, ls, flag, start;
    exp_t e;
    fs = vs && !m_prev_vs;
    ls = de && !m_prev_de;
    m_prev_vs = vs;
    m_prev_de = de;
    if (ls) m_pix = 0;
    else if (de && m_pix < 4095) m_pix++;
    if (fs) begin
      m_line  = 0;
      m_first = 1;
    end
    if (ls) begin
      if (m_first) m_first = 0;
      else if (m_line < 2047) m_line++;
    end
    flag  = 0;
    start = ls && (m_line == LS) && (m_state == 2 || (m_state == 1 && fs));
    case (m_state)
      0: if (arm) m_state = 1;
      1: if (fs) m_state = 2;
      3: if (de) begin
        flag = 1;
        m_cap++;
        if (a != b && m_mm < 65535) m_mm++;
      end
      default: ;
    endcase
    if (start) begin
      flag    = 1;
      m_cap   = 1;
      m_mm    = (a != b) ? 1 : 0;
      m_state = 3;
    end
    if (flag && m_cap == CP) m_state = 4;
    if (!arm) m_state = 0;
    e.p0 = de;
    case (sel)
      2'd0: begin e.p1 = a; e.p2 = b; end
      2'd1: begin e.p1 = a; e.p2 = a ^ b; end
      2'd2: begin e.p1 = m_line[7:0]; e.p2 = m_pix[7:0]; end
      default: begin e.p1 = b; e.p2 = a; end
    endcase
    e.p3 = flag;
    e.st = m_state[2:0];
    e.mm = m_mm[15:0];
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit vs, input bit de, input logic [7:0] a, input logic [7:0] b,
                       input bit arm, input logic [1:0] sel);
    exp_t e;
    vs_i = vs; de_i = de; cha_data_i = a; chb_data_i = b; arm_i = arm; sel_i = sel;
    model_step(vs, de, a, b, arm, sel);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("probe0", 32'(probe0), 32'(e.p0));
    check("probe1", 32'(probe1), 32'(e.p1));
    check("probe2", 32'(probe2), 32'(e.p2));
    check("probe3", 32'(probe3), 32'(e.p3));
    check("state", 32'(state_o), 32'(e.st));
    check("mismatch", 32'(mismatch_cnt_o), 32'(e.mm));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 8'($urandom), 8'($urandom), arm_lvl, 2'd0);
  endtask

  // mm_mode: 0 random A/B, 1 mismatch on odd pixels of line 2 only, 2 A==B always
  task automatic run_frame(input int nlines, input int len, input int gap, input logic [1:0] sel,
                           input int drop_line, input int drop_pix, input int mm_mode,
                           input bit with_vs);
    logic [7:0] a, b;
    if (with_vs) begin
      repeat (2) cycle(1, 0, 8'd0, 8'd0, arm_lvl, sel);
      repeat (2) cycle(0, 0, 8'd0, 8'd0, arm_lvl, sel);
    end
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < len; p++) begin
        if (l == drop_line && p == drop_pix) arm_lvl = 1'b0;
        a = 8'($urandom);
        case (mm_mode)
          0:       b = ($urandom_range(0, 1) == 1) ? ~a : a;
          1:       b = (l == 2 && (p % 2) == 1) ? ~a : a;
          default: b = a;
        endcase
        cycle(0, 1, a, b, arm_lvl, sel);
      end
      repeat (gap) cycle(0, 0, 8'($urandom), 8'($urandom), arm_lvl, sel);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p0"}, 32'(probe0), 32'd0);
    check({tag, "_p1"}, 32'(probe1), 32'd0);
    check({tag, "_p2"}, 32'(probe2), 32'd0);
    check({tag, "_p3"}, 32'(probe3), 32'd0);
    check({tag, "_st"}, 32'(state_o), 32'd0);
    check({tag, "_mm"}, 32'(mismatch_cnt_o), 32'd0);
  endtask

  initial begin
    #12;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Basic latency: 3 clk from input to probes
    cycle(0, 1, 8'h5A, 8'hA5, 0, 2'd0);
    idle(2);
    check("lat_p0", 32'(probe0), 32'd1);
    check("lat_p1", 32'(probe1), 32'h5A);
    check("lat_p2", 32'(probe2), 32'hA5);

    // Every select with random data and DE
    for (int s = 0; s < 4; s++) begin
      repeat (20) cycle(0, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 0, 2'(s));
    end

    // Capture spanning line 2 and part of line 3
    arm_lvl = 1'b1;
    idle(3);
    check("wait_state", 32'(state_o), 32'd1);
    run_frame(5, 10, 3, 2'd0, -1, -1, 0, 1);
    idle(3);
    check("done_state", 32'(state_o), 32'd4);

    // Exactly 5 mismatching captured pixels, count held after disarm
    arm_lvl = 1'b0;
    idle(4);
    arm_lvl = 1'b1;
    idle(3);
    run_frame(5, 10, 3, 2'd0, -1, -1, 1, 1);
    idle(3);
    check("mm5_done", 32'(mismatch_cnt_o), 32'd5);
    check("mm5_state", 32'(state_o), 32'd4);
    arm_lvl = 1'b0;
    idle(4);
    check("mm5_held", 32'(mismatch_cnt_o), 32'd5);
    check("mm5_idle", 32'(state_o), 32'd0);

    // Disarm at captured pixel 7, then re-arm and capture with A==B
    arm_lvl = 1'b1;
    idle(3);
    run_frame(4, 10, 3, 2'd1, 2, 7, 0, 1);
    idle(3);
    check("drop_state", 32'(state_o), 32'd0);
    arm_lvl = 1'b1;
    idle(3);
    run_frame(4, 10, 3, 2'd3, -1, -1, 2, 1);
    idle(3);
    check("rearm_mm", 32'(mismatch_cnt_o), 32'd0);
    check("rearm_state", 32'(state_o), 32'd4);

    // Reset in the middle of a capture
    arm_lvl = 1'b0;
    idle(4);
    arm_lvl = 1'b1;
    idle(3);
    run_frame(3, 10, 3, 2'd0, -1, -1, 0, 1);
    check("pre_rst_cap", 32'(state_o), 32'd3);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_frame(4, 10, 3, 2'd0, -1, -1, 0, 0);
    idle(3);
    check("no_vs_state", 32'(state_o), 32'd1);
    run_frame(4, 10, 3, 2'd0, -1, -1, 0, 1);
    idle(3);
    check("post_rst_done", 32'(state_o), 32'd4);

    // Line/pixel counters: byte wrap, pixel and line saturation
    arm_lvl = 1'b0;
    idle(4);
    run_frame(3, 300, 4, 2'd2, -1, -1, 0, 1);
    run_frame(1, 4200, 2, 2'd2, -1, -1, 0, 1);
    run_frame(2060, 1, 1, 2'd2, -1, -1, 0, 0);

    // Random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) arm_lvl = ~arm_lvl;
      cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00, arm_lvl,
            2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
